// File: rtl/ram_loader.sv
// ram_loader: writes a stream of bytes into the 16x8 program RAM through the
// shared bus and the MAR/RAM control lines, holding the CPU while it does so.
//
// Optional build feature:
//   RAM_LOADER_VERIFY_EN - adds a readback (CHECK) cycle after every write and
//                          a sticky load_error flag; when undefined,
//                          load_error is tied low and the loader never
//                          raises ram_ro.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   load_start          one-cycle pulse, starts a load when idle
//   in_data, in_valid   byte stream in; in_ready high while a byte is wanted
//   cpu_mi/ri/ro        control-unit RAM controls (forwarded only when idle)
//   ram_mi/ri/ro        controls to the RAM/MAR block
//   bus_in              current bus value (readback source)
//   bus_out, bus_oe     value and enable for the external bus driver
//   cpu_hold            halts the CPU while a load is in progress
//   load_done           one-cycle pulse after the final word is written
//   load_error          sticky readback-mismatch flag
module ram_loader #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       cpu_mi,
  input  logic       cpu_ri,
  input  logic       cpu_ro,
  output logic       ram_mi,
  output logic       ram_ri,
  output logic       ram_ro,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_error
);

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
`ifdef RAM_LOADER_VERIFY_EN
    S_CHECK = 3'd4,
`endif
    S_DONE  = 3'd5
  } state_t;

  state_t              state;
  state_t              state_d;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   data;

  // Per-cycle control decisions
  logic                addr_clr;
  logic                addr_inc;
  logic                data_ld;
  logic                last_word;

  // Next values of the registered outputs
  logic                in_ready_d;
  logic                hold_d;
  logic                bus_oe_d;
  logic [DATA_W-1:0]   bus_out_d;
  logic                done_d;
  logic                mi_d;
  logic                ri_d;
  logic                ro_d;

  // Loader-owned RAM controls, used only while the CPU is held
  logic                mi_q;
  logic                ri_q;
  logic                ro_q;

  assign last_word = (addr == LAST_ADDR);

  // Next-state decision from the current state, then output decode of the
  // next state so every output lands in a register aligned with its state.
  always_comb begin
    state_d    = state;
    addr_clr   = 1'b0;
    addr_inc   = 1'b0;
    data_ld    = 1'b0;
    in_ready_d = 1'b0;
    hold_d     = 1'b0;
    bus_oe_d   = 1'b0;
    bus_out_d  = '0;
    done_d     = 1'b0;
    mi_d       = 1'b0;
    ri_d       = 1'b0;
    ro_d       = 1'b0;

    case (state)
      S_IDLE: begin
        if (load_start) begin
          state_d  = S_WAIT;
          addr_clr = 1'b1;
        end
      end
      S_WAIT: begin
        if (in_valid && in_ready) begin
          state_d = S_ADDR;
          data_ld = 1'b1;
        end
      end
      S_ADDR: state_d = S_DATA;
`ifdef RAM_LOADER_VERIFY_EN
      S_DATA: state_d = S_CHECK;
      S_CHECK: begin
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_WAIT;
          addr_inc = 1'b1;
        end
      end
`else
      S_DATA: begin
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_WAIT;
          addr_inc = 1'b1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_WAIT: begin
        hold_d     = 1'b1;
        in_ready_d = 1'b1;
      end
      S_ADDR: begin
        // Address is stable from WAIT through the write, so it is safe to use here.
        hold_d    = 1'b1;
        bus_oe_d  = 1'b1;
        bus_out_d = {4'h0, addr};
        mi_d      = 1'b1;
      end
      S_DATA: begin
        hold_d    = 1'b1;
        bus_oe_d  = 1'b1;
        bus_out_d = data;
        ri_d      = 1'b1;
      end
`ifdef RAM_LOADER_VERIFY_EN
      S_CHECK: begin
        hold_d = 1'b1;
        ro_d   = 1'b1;
      end
`endif
      S_DONE: begin
        hold_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State, address/data registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      data      <= '0;
      in_ready  <= 1'b0;
      cpu_hold  <= 1'b0;
      bus_oe    <= 1'b0;
      bus_out   <= '0;
      load_done <= 1'b0;
      mi_q      <= 1'b0;
      ri_q      <= 1'b0;
      ro_q      <= 1'b0;
    end else begin
      state     <= state_d;
      in_ready  <= in_ready_d;
      cpu_hold  <= hold_d;
      bus_oe    <= bus_oe_d;
      bus_out   <= bus_out_d;
      load_done <= done_d;
      mi_q      <= mi_d;
      ri_q      <= ri_d;
      ro_q      <= ro_d;
      if (addr_clr) begin
        addr <= '0;
      end else if (addr_inc) begin
        addr <= addr + ADDR_W'(1);
      end
      if (data_ld) begin
        data <= in_data;
      end
    end
  end

  // CPU controls pass straight through while idle; the loader owns them otherwise.
  assign ram_mi = cpu_hold ? mi_q : cpu_mi;
  assign ram_ri = cpu_hold ? ri_q : cpu_ri;
  assign ram_ro = cpu_hold ? ro_q : cpu_ro;

`ifdef RAM_LOADER_VERIFY_EN
  logic err_q;

  // Readback compare at the end of each CHECK cycle; cleared only by a new load.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (addr_clr) begin
      err_q <= 1'b0;
    end else if (state == S_CHECK && bus_in != data) begin
      err_q <= 1'b1;
    end
  end

  assign load_error = err_q;
`else
  logic unused_bus_in;

  assign unused_bus_in = ^bus_in;
  assign load_error    = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: randomized self-checking bench for ram_loader. A behavioural
// RAM/MAR model reacts to the loader's bus and controls and logs every write;
// the expected write sequence, done timing and error flag come from the
// stimulus bytes and the load rules.
`timescale 1ns/1ps
module tb_ram_loader;

`ifdef RAM_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int DEPTH    = 16;
  localparam int WORD_CYC = VERIFY ? 4 : 3;
  localparam int BUDGET   = 600;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       cpu_mi, cpu_ri, cpu_ro;
  logic       ram_mi, ram_ri, ram_ro;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       cpu_hold;
  logic       load_done;
  logic       load_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ram_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cpu_mi(cpu_mi), .cpu_ri(cpu_ri), .cpu_ro(cpu_ro),
    .ram_mi(ram_mi), .ram_ri(ram_ri), .ram_ro(ram_ro),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM/MAR model: MAR captures the bus on mi, RAM word written on ri.
  logic [7:0]  mem [DEPTH];
  logic [3:0]  mar = 4'd0;
  logic [11:0] wlog [$];
  logic        corrupt_en = 1'b0;
  logic [7:0]  bus_val;

  assign bus_val = bus_oe ? bus_out : 8'h00;
  assign bus_in  = ram_ro ? ((corrupt_en && mar == 4'd3) ? 8'hFF : mem[mar]) : 8'h00;

  always @(posedge clk) begin
    if (ram_mi) mar <= bus_val[3:0];
    if (ram_ri) begin
      mem[mar] <= bus_val;
      wlog.push_back({mar, bus_val});
    end
  end

  logic [7:0] stim [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 0);
    check({tag, "_bus_oe"}, bus_oe, 0);
    check({tag, "_bus_out"}, bus_out, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_load_error"}, load_error, 0);
    check({tag, "_pass"}, {ram_mi, ram_ri, ram_ro}, {cpu_mi, cpu_ri, cpu_ro});
  endtask

  // Written words must be exactly addresses 0,1,2.. in order carrying stim[k].
  task automatic check_writes(input int expect_n);
    logic [11:0] e;
    if (expect_n >= 0) check("write_count", wlog.size(), expect_n);
    for (int k = 0; k < wlog.size() && k < DEPTH; k++) begin
      e = wlog[k];
      check("write_addr", e[11:8], k);
      check("write_data", e[7:0], stim[k]);
      check("ram_word", mem[k], stim[k]);
    end
  endtask

  // mode: 0 in_valid always high, 1 one-on/three-off, 2 random.
  // restart_at >= 0: pulse load_start again while that word is in flight.
  // rst_at >= 0: stop feeding once that many bytes were accepted (reset test).
  task automatic run_load(input int mode, input int restart_at, input int rst_at,
                          input bit corrupt, output int done_cnt);
    int  idx, start, done_cyc, n;
    bit  restarted, v;
    wlog.delete();
    corrupt_en = corrupt;
    idx = 0; done_cnt = 0; done_cyc = -1; restarted = 0;
    @(negedge clk);
    load_start = 1'b1;
    start = cyc;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      load_start = 1'b0;
      if (n > BUDGET) begin
        check("load_timeout", 1, 0);
        break;
      end
      check("mi_ri_excl", ram_mi & ram_ri, 0);
      check("oe_ro_excl", bus_oe & ram_ro, 0);
      if (n == 1) begin
        check("in_ready_rise", in_ready, 1);
        check("cpu_hold_rise", cpu_hold, 1);
        check("err_cleared", load_error, 0);
      end
      if (load_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (rst_at >= 0 && idx == rst_at) break;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        check("hold_released", cpu_hold, 0);
        check("in_ready_low", in_ready, 0);
        break;
      end
      {cpu_mi, cpu_ri, cpu_ro} = (cpu_hold && !load_done) ? 3'($urandom) : 3'b000;
      case (mode)
        0:       v = 1'b1;
        1:       v = (n % 4) == 1;
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v && (idx < DEPTH);
      in_data  = (idx < DEPTH) ? stim[idx] : 8'($urandom);
      if (in_valid && in_ready) idx++;
      if (restart_at >= 0 && !restarted && idx == restart_at + 1) begin
        load_start = 1'b1;
        restarted  = 1'b1;
      end
    end
    in_valid = 1'b0;
    {cpu_mi, cpu_ri, cpu_ro} = 3'b000;
    if (rst_at < 0) begin
      check("done_pulses", done_cnt, 1);
      if (mode == 0) check("done_cycle", done_cyc - start, 1 + DEPTH * WORD_CYC);
      check("load_error", load_error, VERIFY && corrupt && stim[3] != 8'hFF);
      check_writes(DEPTH);
    end
  endtask

  initial begin
    int dc;
    logic [2:0] p;
    for (int k = 0; k < DEPTH; k++) mem[k] = 8'h00;
    rst = 1'b1; load_start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    cpu_mi = 1'b0; cpu_ri = 1'b0; cpu_ro = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Passthrough in IDLE (restored before the next edge so no RAM write occurs)
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      p = (i == 0) ? 3'b101 : 3'($urandom);
      {cpu_mi, cpu_ri, cpu_ro} = p;
      #1;
      check("pass_ram", {ram_mi, ram_ri, ram_ro}, p);
      check("pass_oe", bus_oe, 0);
      {cpu_mi, cpu_ri, cpu_ro} = 3'b000;
    end

    // Full load, descending byte pattern, in_valid held high
    for (int k = 0; k < DEPTH; k++) stim[k] = 8'h50 - 8'(k);
    run_load(0, -1, -1, 1'b0, dc);

    // Backpressure one-on/three-off
    for (int k = 0; k < DEPTH; k++) stim[k] = 8'($urandom);
    run_load(1, -1, -1, 1'b0, dc);

    // Second load_start during word 5 must be ignored
    for (int k = 0; k < DEPTH; k++) stim[k] = 8'($urandom);
    run_load(0, 5, -1, 1'b0, dc);

    // Random valid gaps
    for (int k = 0; k < DEPTH; k++) stim[k] = 8'($urandom);
    run_load(2, -1, -1, 1'b0, dc);

    // Reset for two cycles mid-load
    for (int k = 0; k < DEPTH; k++) stim[k] = 8'($urandom);
    run_load(0, -1, 7, 1'b0, dc);
    rst = 1'b1;
    {cpu_mi, cpu_ri, cpu_ro} = 3'b101;
    @(negedge clk);
    check_reset_outs("midrst1");
    @(negedge clk);
    check_reset_outs("midrst2");
    rst = 1'b0;
    {cpu_mi, cpu_ri, cpu_ro} = 3'b000;
    check("midrst_no_done", dc, 0);
    check("midrst_partial", wlog.size() <= 7 && wlog.size() >= 5, 1);
    check_writes(-1);
    @(negedge clk);
    check("midrst_idle_hold", cpu_hold, 0);

    // Readback corrupted on word 3; flag must persist past load_done
    for (int k = 0; k < DEPTH; k++) stim[k] = 8'($urandom);
    stim[3] = 8'h1B;
    run_load(0, -1, -1, 1'b1, dc);
    repeat (3) @(negedge clk);
    check("err_sticky_idle", load_error, VERIFY);

    // Next load clears the flag and runs clean
    for (int k = 0; k < DEPTH; k++) stim[k] = 8'($urandom);
    run_load(2, -1, -1, 1'b0, dc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
